axi_wr_path: RTL and testbench



---
 rtl/ddr3_axi_pkg.sv | 17 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/axi_wr_path.sv | 115 +++++++++++
 tb/tb_axi_wr_path.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_axi_pkg.sv
// ddr3_axi_pkg: AXI constants shared by the DDR3 controller read and write paths.
package ddr3_axi_pkg;

    localparam logic [1:0] BURST_FIXED  = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    function automatic logic [1:0] bresp_of(input logic err);
        return err ? BRESP_SLVERR : BRESP_OKAY;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock ready/valid FIFO; BLOCK=1 adds a registered output stage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int BLOCK = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);
    localparam int CBITS = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CBITS-1:0] wr_q, rd_q;
    logic [CBITS:0]   count_q;
    logic             push, pop, avail;

    // Ready depends only on occupancy and reset, never on in_valid_i.
    assign in_ready_o = !reset && count_q != (CBITS+1)'(DEPTH);
    assign push       = in_valid_i & in_ready_o;
    assign avail      = count_q != '0;

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_q + CBITS'(push);
            rd_q    <= rd_q + CBITS'(pop);
            count_q <= count_q + (CBITS+1)'(push) - (CBITS+1)'(pop);
        end
    end

    if (BLOCK != 0) begin : g_reg
        logic             out_valid_q;
        logic [WIDTH-1:0] out_data_q;
        assign pop         = avail & (!out_valid_q | out_ready_i);
        assign out_valid_o = out_valid_q & !reset;
        assign out_data_o  = out_data_q;
        always_ff @(posedge clock) begin
            if (reset) out_valid_q <= 1'b0;
            else if (!out_valid_q || out_ready_i) out_valid_q <= avail;
        end
        always_ff @(posedge clock) begin
            if (pop) out_data_q <= mem_q[rd_q];
        end
    end else begin : g_comb
        assign pop         = avail & out_ready_i & !reset;
        assign out_valid_o = avail & !reset;
        assign out_data_o  = mem_q[rd_q];
    end

endmodule

// File: rtl/axi_wr_path.sv
// axi_wr_path: AXI4 write front end; releases a store command only once its burst is fully
// buffered and returns B responses in order after memory has taken each burst's last beat.
module axi_wr_path
    import ddr3_axi_pkg::*;
#(
    parameter int ADDRS           = 32,
    parameter int WIDTH           = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int CTRL_FIFO_DEPTH = 16,
    parameter int DATA_FIFO_DEPTH = 512,
    parameter int DATA_FIFO_BLOCK = 1,
    localparam int MASKS          = WIDTH / 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDRS-1:0]        axi_awaddr_i,
    input  logic [AXI_ID_WIDTH-1:0] axi_awid_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic                    axi_wlast_i,
    input  logic [MASKS-1:0]        axi_wstrb_i,
    input  logic [WIDTH-1:0]        axi_wdata_i,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [AXI_ID_WIDTH-1:0] axi_bid_o,
    output logic                    mem_store_o,
    input  logic                    mem_accept_i,
    output logic [AXI_ID_WIDTH-1:0] mem_wrid_o,
    output logic [ADDRS-1:0]        mem_addr_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic                    mem_last_o,
    output logic [MASKS-1:0]        mem_strb_o,
    output logic [WIDTH-1:0]        mem_data_o
);
    localparam int CBITS = $clog2(CTRL_FIFO_DEPTH);

    logic                    cmd_in_ready, cmd_out_valid, len_in_ready, len_out_valid;
    logic                    rsp_in_ready, rsp_out_valid, rsp_err, dat_in_ready;
    logic [7:0]              len_out;
    logic [AXI_ID_WIDTH-1:0] len_id;
    logic                    aw_fire, w_fire, w_end, store_fire, beat_retire, b_fire;
    logic [7:0]              beats_q, beats_d;
    logic [CBITS:0]          ready_bursts_q, ready_bursts_d, retired_q, retired_d;

    assign axi_awready_o = cmd_in_ready & len_in_ready;
    assign aw_fire       = axi_awvalid_i & axi_awready_o;
    assign axi_wready_o  = dat_in_ready & len_out_valid & rsp_in_ready;
    assign w_fire        = axi_wvalid_i & axi_wready_o;
    assign w_end         = w_fire & axi_wlast_i;
    assign mem_store_o   = cmd_out_valid & (ready_bursts_q != '0);
    assign store_fire    = mem_store_o & mem_accept_i;
    assign beat_retire   = mem_valid_o & mem_ready_i & mem_last_o;
    assign axi_bvalid_o  = rsp_out_valid & (retired_q != '0);
    assign b_fire        = axi_bvalid_o & axi_bready_i;
    assign axi_bresp_o   = bresp_of(rsp_err);

    // beats_q counts beats already taken, so at wlast it equals awlen for a correct burst.
    always_comb begin
        beats_d        = w_end ? '0 : beats_q + 8'(w_fire);
        ready_bursts_d = ready_bursts_q + (CBITS+1)'(w_end) - (CBITS+1)'(store_fire);
        retired_d      = retired_q + (CBITS+1)'(beat_retire) - (CBITS+1)'(b_fire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            beats_q        <= '0;
            ready_bursts_q <= '0;
            retired_q      <= '0;
        end else begin
            beats_q        <= beats_d;
            ready_bursts_q <= ready_bursts_d;
            retired_q      <= retired_d;
        end
    end

    sync_fifo #(.WIDTH(ADDRS + AXI_ID_WIDTH), .DEPTH(CTRL_FIFO_DEPTH), .BLOCK(0)) u_cmd (
        .clock(clock), .reset(reset),
        .in_valid_i(aw_fire), .in_ready_o(cmd_in_ready), .in_data_i({axi_awaddr_i, axi_awid_i}),
        .out_valid_o(cmd_out_valid), .out_ready_i(store_fire), .out_data_o({mem_addr_o, mem_wrid_o})
    );

    sync_fifo #(.WIDTH(8 + AXI_ID_WIDTH), .DEPTH(CTRL_FIFO_DEPTH), .BLOCK(0)) u_len (
        .clock(clock), .reset(reset),
        .in_valid_i(aw_fire), .in_ready_o(len_in_ready), .in_data_i({axi_awlen_i, axi_awid_i}),
        .out_valid_o(len_out_valid), .out_ready_i(w_end), .out_data_o({len_out, len_id})
    );

    sync_fifo #(.WIDTH(AXI_ID_WIDTH + 1), .DEPTH(CTRL_FIFO_DEPTH), .BLOCK(0)) u_rsp (
        .clock(clock), .reset(reset),
        .in_valid_i(w_end), .in_ready_o(rsp_in_ready), .in_data_i({len_id, beats_q != len_out}),
        .out_valid_o(rsp_out_valid), .out_ready_i(b_fire), .out_data_o({axi_bid_o, rsp_err})
    );

    sync_fifo #(.WIDTH(1 + MASKS + WIDTH), .DEPTH(DATA_FIFO_DEPTH), .BLOCK(DATA_FIFO_BLOCK)) u_dat (
        .clock(clock), .reset(reset),
        .in_valid_i(w_fire), .in_ready_o(dat_in_ready),
        .in_data_i({axi_wlast_i, axi_wstrb_i, axi_wdata_i}),
        .out_valid_o(mem_valid_o), .out_ready_i(mem_ready_i),
        .out_data_o({mem_last_o, mem_strb_o, mem_data_o})
    );

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset && aw_fire && axi_awburst_i != BURST_INCR)
            $fatal(1, "axi_wr_path: unsupported awburst %b", axi_awburst_i);
    end
`endif

endmodule

// File: tb/tb_axi_wr_path.sv
// tb_axi_wr_path: table-driven bursts plus corner sequences, checked by queue scoreboards.
module tb_axi_wr_path;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        axi_awvalid_i = 1'b0, axi_awready_o;
    logic [31:0] axi_awaddr_i = '0;
    logic [3:0]  axi_awid_i = '0;
    logic [7:0]  axi_awlen_i = '0;
    logic [1:0]  axi_awburst_i = 2'b01;
    logic        axi_wvalid_i = 1'b0, axi_wready_o, axi_wlast_i = 1'b0;
    logic [3:0]  axi_wstrb_i = '0;
    logic [31:0] axi_wdata_i = '0;
    logic        axi_bvalid_o, axi_bready_i = 1'b1;
    logic [1:0]  axi_bresp_o;
    logic [3:0]  axi_bid_o, mem_wrid_o, mem_strb_o;
    logic        mem_store_o, mem_accept_i = 1'b1;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_valid_o, mem_ready_i = 1'b1, mem_last_o;

    int checks = 0;
    int errors = 0;
    logic [35:0] exp_cmd[$];
    logic [36:0] exp_beat[$];
    logic [5:0]  exp_b[$];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        int          nbeats;
        logic [3:0]  strb;
        logic [1:0]  resp;
    } vec_t;
    vec_t vecs[6];

    always #5 clock = ~clock;

    axi_wr_path dut (
        .clock(clock), .reset(reset),
        .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
        .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awburst_i(axi_awburst_i),
        .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wlast_i(axi_wlast_i),
        .axi_wstrb_i(axi_wstrb_i), .axi_wdata_i(axi_wdata_i),
        .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bresp_o(axi_bresp_o),
        .axi_bid_o(axi_bid_o), .mem_store_o(mem_store_o), .mem_accept_i(mem_accept_i),
        .mem_wrid_o(mem_wrid_o), .mem_addr_o(mem_addr_o), .mem_valid_o(mem_valid_o),
        .mem_ready_i(mem_ready_i), .mem_last_o(mem_last_o), .mem_strb_o(mem_strb_o),
        .mem_data_o(mem_data_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Handshakes complete on the posedge following the negedge where both sides are seen high.
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_store_o && mem_accept_i) begin
                if (exp_cmd.size() == 0) fail("unexpected mem cmd");
                else check("mem cmd", 64'({mem_addr_o, mem_wrid_o}), 64'(exp_cmd.pop_front()));
            end
            if (mem_valid_o && mem_ready_i) begin
                if (exp_beat.size() == 0) fail("unexpected mem beat");
                else check("mem beat", 64'({mem_last_o, mem_strb_o, mem_data_o}), 64'(exp_beat.pop_front()));
            end
            if (axi_bvalid_o && axi_bready_i) begin
                if (exp_b.size() == 0) fail("unexpected B");
                else check("B id/resp", 64'({axi_bid_o, axi_bresp_o}), 64'(exp_b.pop_front()));
            end
        end
    end

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        int n = 0;
        axi_awaddr_i = a; axi_awid_i = id; axi_awlen_i = len; axi_awvalid_i = 1'b1;
        do begin @(negedge clock); n++; end while (!axi_awready_o && n < 500);
        if (!axi_awready_o) fail("aw handshake timeout");
        @(posedge clock); #1 axi_awvalid_i = 1'b0;
    endtask

    task automatic w_beat(input logic last, input logic [3:0] s, input logic [31:0] d);
        int n = 0;
        axi_wlast_i = last; axi_wstrb_i = s; axi_wdata_i = d; axi_wvalid_i = 1'b1;
        do begin @(negedge clock); n++; end while (!axi_wready_o && n < 500);
        if (!axi_wready_o) fail("w handshake timeout");
        @(posedge clock); #1 axi_wvalid_i = 1'b0;
    endtask

    task automatic burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                         input int nbeats, input logic [3:0] s, input logic [1:0] resp);
        exp_cmd.push_back({a, id});
        exp_b.push_back({id, resp});
        fork
            aw_send(a, id, len);
            for (int i = 0; i < nbeats; i++) begin
                logic [31:0] d = $urandom;
                exp_beat.push_back({i == nbeats - 1, s, d});
                w_beat(i == nbeats - 1, s, d);
            end
        join
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_cmd.size() || exp_beat.size() || exp_b.size()) && n < 400) begin
            @(negedge clock); n++;
        end
        if (exp_cmd.size() || exp_beat.size() || exp_b.size()) fail(name);
        @(posedge clock); #1;
    endtask

    initial begin
        logic bad;
        int n;
        vecs[0] = '{32'h0000_1000, 4'd5,  8'd3,  4,  4'hF, 2'b00};
        vecs[1] = '{32'h0000_2000, 4'd3,  8'd0,  1,  4'h1, 2'b00};
        vecs[2] = '{32'h0000_3000, 4'd7,  8'd3,  2,  4'h3, 2'b10};
        vecs[3] = '{32'h0000_4000, 4'd9,  8'd1,  3,  4'hC, 2'b10};
        vecs[4] = '{32'h0000_5000, 4'd15, 8'd7,  8,  4'hA, 2'b00};
        vecs[5] = '{32'h0000_6000, 4'd0,  8'd15, 16, 4'h5, 2'b00};

        repeat (3) @(negedge clock);
        check("reset outputs", 64'({axi_awready_o, axi_wready_o, mem_store_o, mem_valid_o, axi_bvalid_o}), 64'h0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        check("awready after reset", 64'(axi_awready_o), 64'h1);
        check("wready idle", 64'(axi_wready_o), 64'h0);
        @(posedge clock); #1;

        foreach (vecs[i]) begin
            burst(vecs[i].addr, vecs[i].id, vecs[i].len, vecs[i].nbeats, vecs[i].strb, vecs[i].resp);
            drain("table drain");
        end

        // Latency of a single-beat burst with memory holding both handshakes off.
        mem_accept_i = 1'b0; mem_ready_i = 1'b0;
        exp_cmd.push_back({32'h7000, 4'd2});
        exp_b.push_back({4'd2, 2'b00});
        exp_beat.push_back({1'b1, 4'hF, 32'hCAFE_0001});
        aw_send(32'h7000, 4'd2, 8'd0);
        w_beat(1'b1, 4'hF, 32'hCAFE_0001);
        @(negedge clock);
        check("store at t+1", 64'({mem_store_o, mem_valid_o}), 64'b10);
        @(negedge clock);
        check("mem_valid at t+2", 64'(mem_valid_o), 64'h1);
        @(posedge clock); #1 mem_accept_i = 1'b1; mem_ready_i = 1'b1;
        drain("latency drain");

        // W ahead of AW stalls without losing beats.
        exp_cmd.push_back({32'h7100, 4'd11});
        exp_b.push_back({4'd11, 2'b00});
        fork
            for (int i = 0; i < 2; i++) begin
                logic [31:0] d = 32'hBEEF_0000 + i;
                exp_beat.push_back({i == 1, 4'h6, d});
                w_beat(i == 1, 4'h6, d);
            end
            begin
                bad = 1'b0;
                repeat (6) begin @(negedge clock); if (axi_wready_o) bad = 1'b1; end
                check("wready held before AW", 64'(bad), 64'h0);
                @(posedge clock); #1;
                aw_send(32'h7100, 4'd11, 8'd1);
            end
        join
        drain("early W drain");

        // bvalid must wait for the last beat to be taken by memory.
        mem_ready_i = 1'b0;
        burst(32'h8000, 4'd6, 8'd3, 4, 4'hF, 2'b00);
        bad = 1'b0;
        repeat (20) begin @(negedge clock); if (axi_bvalid_o) bad = 1'b1; end
        check("bvalid held while mem stalled", 64'(bad), 64'h0);
        @(posedge clock); #1 mem_ready_i = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!(mem_valid_o && mem_last_o) && n < 50);
        if (!(mem_valid_o && mem_last_o)) fail("last beat timeout");
        check("bvalid before last accept", 64'(axi_bvalid_o), 64'h0);
        @(negedge clock);
        check("bvalid after last accept", 64'(axi_bvalid_o), 64'h1);
        drain("bvalid drain");

        // Sixteen pending responses fill the response FIFO and throttle W.
        axi_bready_i = 1'b0;
        for (int i = 0; i < 16; i++) burst(32'hA000 + 32'(i * 16), 4'(i), 8'd0, 1, 4'hF, 2'b00);
        exp_cmd.push_back({32'hA100, 4'd1});
        exp_b.push_back({4'd1, 2'b00});
        aw_send(32'hA100, 4'd1, 8'd0);
        repeat (3) @(negedge clock);
        check("wready with 16 pending", 64'(axi_wready_o), 64'h0);
        @(posedge clock); #1 axi_bready_i = 1'b1;
        @(negedge clock);
        check("bvalid with 16 pending", 64'(axi_bvalid_o), 64'h1);
        @(posedge clock); #1 axi_bready_i = 1'b0;
        @(negedge clock);
        check("wready after one B", 64'(axi_wready_o), 64'h1);
        @(posedge clock); #1;
        exp_beat.push_back({1'b1, 4'h9, 32'h1717_1717});
        w_beat(1'b1, 4'h9, 32'h1717_1717);
        axi_bready_i = 1'b1;
        drain("throttle drain");

        // Reset mid-burst discards it; the next burst completes normally.
        mem_ready_i = 1'b0;
        fork
            aw_send(32'hB000, 4'd8, 8'd3);
            begin w_beat(1'b0, 4'hF, 32'h1); w_beat(1'b0, 4'hF, 32'h2); end
        join
        reset = 1'b1;
        @(negedge clock);
        check("outputs in reset", 64'({axi_awready_o, axi_wready_o, mem_store_o, mem_valid_o, axi_bvalid_o}), 64'h0);
        @(posedge clock); #1 reset = 1'b0; mem_ready_i = 1'b1;
        @(negedge clock);
        check("outputs after mid-burst reset", 64'({axi_awready_o, axi_wready_o, mem_store_o, mem_valid_o, axi_bvalid_o}), 64'b10000);
        @(posedge clock); #1;
        burst(32'hC000, 4'd4, 8'd0, 1, 4'hF, 2'b00);
        drain("post-reset drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end
endmodule
